popcount_pipe: RTL and testbench

POPCOUNT_PIPE -- requirements
Module: popcount_pipe

---
 rtl/popcount_pipe.sv | 151 +++++++++++++++
 tb/tb_popcount_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_pipe.sv
// Pipelined population counter with per-frame running total.
//
// Each input beat is reduced to a bit count. Mode 0 counts ones and mode 1 counts zeros; the mode
// is sampled with the beat. The count comes from a registered leaf stage followed by one
// registered adder-tree level per stage. A final stage adds each count to a saturating frame
// accumulator, which clears after the beat that closes the frame.
//
// Parameters:
//   WIDTH  input word width (WIDTH/LEAF must be a power of two)
//   LEAF   bits counted per leaf group
//   ACC_W  frame accumulator width (>= CNT_W)
//
// Ports:
//   clk_i        clock, rising edge
//   rstn_i       asynchronous active-low reset
//   data_val_i   input beat valid
//   data_rdy_o   input beat accepted this cycle (equals pipeline enable)
//   data_i       input word
//   data_last_i  beat closes the current frame
//   mode_i       0 = count ones, 1 = count zeros
//   data_val_o   output beat valid
//   data_rdy_i   downstream accepts output beat
//   data_o       per-beat count
//   sum_o        frame total including this beat, saturating
//   last_o       this beat closes its frame
//   sat_o        frame total saturated at or before this beat
module popcount_pipe #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned LEAF  = 4,
   parameter int unsigned ACC_W = 16,
   localparam int unsigned CNT_W = $clog2(WIDTH + 1),
   localparam int unsigned NLVL  = $clog2(WIDTH / LEAF)
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             data_val_i,
   output logic             data_rdy_o,
   input  logic [WIDTH-1:0] data_i,
   input  logic             data_last_i,
   input  logic             mode_i,
   output logic             data_val_o,
   input  logic             data_rdy_i,
   output logic [CNT_W-1:0] data_o,
   output logic [ACC_W-1:0] sum_o,
   output logic             last_o,
   output logic             sat_o
);

   localparam int unsigned NLEAF = WIDTH / LEAF;

   // Whole pipeline moves in lockstep; it stalls only when the output is held by downstream.
   logic en;
   assign en         = !data_val_o || data_rdy_i;
   assign data_rdy_o = en;

   // Level 0 holds leaf counts; level l holds NLEAF >> l partial sums.
   for (genvar l = 0; l <= NLVL; l++) begin : g_lvl
      localparam int unsigned N = NLEAF >> l;
      logic [CNT_W-1:0] cnt_q [N];
      logic             val_q;
      logic             last_q;

      if (l == 0) begin : g_leaf
         logic [WIDTH-1:0] word;
         logic [CNT_W-1:0] cnt_d [N];

         // Mode is folded into the leaf counts here, so it need not travel down the tree.
         always_comb begin
            word = mode_i ? ~data_i : data_i;
            for (int i = 0; i < N; i++) begin
               cnt_d[i] = '0;
               for (int b = 0; b < LEAF; b++) begin
                  cnt_d[i] = cnt_d[i] + CNT_W'(word[i*LEAF+b]);
               end
            end
         end

         always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
               val_q  <= 1'b0;
               last_q <= 1'b0;
               for (int i = 0; i < N; i++) cnt_q[i] <= '0;
            end else if (en) begin
               val_q  <= data_val_i;
               last_q <= data_last_i;
               cnt_q  <= cnt_d;
            end
         end
      end else begin : g_add
         always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
               val_q  <= 1'b0;
               last_q <= 1'b0;
               for (int i = 0; i < N; i++) cnt_q[i] <= '0;
            end else if (en) begin
               val_q  <= g_lvl[l-1].val_q;
               last_q <= g_lvl[l-1].last_q;
               for (int i = 0; i < N; i++) begin
                  cnt_q[i] <= g_lvl[l-1].cnt_q[2*i] + g_lvl[l-1].cnt_q[2*i+1];
               end
            end
         end
      end
   end

   logic [CNT_W-1:0] top_cnt;
   logic             top_val;
   logic             top_last;
   assign top_cnt  = g_lvl[NLVL].cnt_q[0];
   assign top_val  = g_lvl[NLVL].val_q;
   assign top_last = g_lvl[NLVL].last_q;

   // Frame accumulator: acc_q/sat_q carry the total of the frame in progress.
   logic [ACC_W-1:0] acc_q;
   logic             sat_q;
   logic [ACC_W:0]   sum_full;
   logic             ovf;
   logic [ACC_W-1:0] sum_d;
   logic             sat_d;

   always_comb begin
      sum_full = {1'b0, acc_q} + (ACC_W + 1)'(top_cnt);
      ovf      = sum_full[ACC_W];
      sum_d    = ovf ? '1 : sum_full[ACC_W-1:0];
      sat_d    = sat_q || ovf;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         data_val_o <= 1'b0;
         data_o     <= '0;
         sum_o      <= '0;
         last_o     <= 1'b0;
         sat_o      <= 1'b0;
         acc_q      <= '0;
         sat_q      <= 1'b0;
      end else if (en) begin
         data_val_o <= top_val;
         if (top_val) begin
            data_o <= top_cnt;
            sum_o  <= sum_d;
            last_o <= top_last;
            sat_o  <= sat_d;
            // A closing beat leaves the accumulator empty for the next frame.
            acc_q  <= top_last ? '0 : sum_d;
            sat_q  <= top_last ? 1'b0 : sat_d;
         end
      end
   end

endmodule

// File: tb/tb_popcount_pipe.sv
module tb_popcount_pipe;

   typedef struct {
      logic [31:0] d;
      logic [31:0] s;
      logic        l;
      logic        t;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        data_val_i;
   logic [31:0] data_i;
   logic        data_last_i;
   logic        mode_i;
   logic        data_rdy_i;
   logic        rdy_force;
   logic        tog_en;
   logic        tog_v;
   logic        use6;
   logic        b_val_i;

   logic        data_rdy_o, data_val_o, last_o, sat_o;
   logic [5:0]  data_o;
   logic [15:0] sum_o;
   logic        b_rdy_o, b_val_o, b_last_o, b_sat_o;
   logic [5:0]  b_data_o;
   logic [5:0]  b_sum_o;

   int total = 0;
   int bad   = 0;
   int tcnt  = 0;
   exp_t exp_q[$];
   exp_t exp6_q[$];

   assign data_rdy_i = tog_en ? tog_v : rdy_force;
   assign b_val_i    = data_val_i && use6;

   popcount_pipe #(.WIDTH(32), .LEAF(4), .ACC_W(16)) u_dut (
      .clk_i      (clk),
      .rstn_i     (rst_n),
      .data_val_i (data_val_i),
      .data_rdy_o (data_rdy_o),
      .data_i     (data_i),
      .data_last_i(data_last_i),
      .mode_i     (mode_i),
      .data_val_o (data_val_o),
      .data_rdy_i (data_rdy_i),
      .data_o     (data_o),
      .sum_o      (sum_o),
      .last_o     (last_o),
      .sat_o      (sat_o)
   );

   popcount_pipe #(.WIDTH(32), .LEAF(4), .ACC_W(6)) u_dut6 (
      .clk_i      (clk),
      .rstn_i     (rst_n),
      .data_val_i (b_val_i),
      .data_rdy_o (b_rdy_o),
      .data_i     (data_i),
      .data_last_i(data_last_i),
      .mode_i     (mode_i),
      .data_val_o (b_val_o),
      .data_rdy_i (data_rdy_i),
      .data_o     (b_data_o),
      .sum_o      (b_sum_o),
      .last_o     (b_last_o),
      .sat_o      (b_sat_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Ready pattern 1,0,0 repeating while enabled.
   always @(posedge clk) begin
      #1;
      if (tog_en) begin
         tog_v = (tcnt % 3 == 0);
         tcnt++;
      end
   end

   // Scoreboard for the 16-bit accumulator instance, plus stall-stability tracking.
   logic        held = 1'b0;
   logic [31:0] held_d, held_s;
   always @(negedge clk) begin
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (held) begin
            chk("hold_val", {31'b0, data_val_o}, 32'd1);
            chk("hold_data", {26'b0, data_o}, held_d);
            chk("hold_sum", {16'b0, sum_o}, held_s);
         end
         if (data_val_o && data_rdy_i) begin
            if (exp_q.size() == 0) begin
               chk("extra_beat", {31'b0, data_val_o}, 32'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("data", {26'b0, data_o}, e.d);
               chk("sum", {16'b0, sum_o}, e.s);
               chk("last", {31'b0, last_o}, {31'b0, e.l});
               chk("sat", {31'b0, sat_o}, {31'b0, e.t});
            end
         end
         held   = data_val_o && !data_rdy_i;
         held_d = {26'b0, data_o};
         held_s = {16'b0, sum_o};
      end
   end

   // Scoreboard for the 6-bit accumulator instance.
   always @(negedge clk) begin
      if (rst_n && b_val_o && data_rdy_i) begin
         if (exp6_q.size() == 0) begin
            chk("extra_beat6", {31'b0, b_val_o}, 32'd0);
         end else begin
            exp_t e;
            e = exp6_q.pop_front();
            chk("data6", {26'b0, b_data_o}, e.d);
            chk("sum6", {26'b0, b_sum_o}, e.s);
            chk("last6", {31'b0, b_last_o}, {31'b0, e.l});
            chk("sat6", {31'b0, b_sat_o}, {31'b0, e.t});
         end
      end
   end

   task automatic expect_a(input int d, input int s, input logic l, input logic t);
      exp_t e;
      e.d = d; e.s = s; e.l = l; e.t = t;
      exp_q.push_back(e);
   endtask

   task automatic expect_b(input int d, input int s, input logic l, input logic t);
      exp_t e;
      e.d = d; e.s = s; e.l = l; e.t = t;
      exp6_q.push_back(e);
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic send(input logic [31:0] d, input logic m, input logic l);
      logic acc;
      int   n;
      data_i      = d;
      mode_i      = m;
      data_last_i = l;
      data_val_i  = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = data_rdy_o;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
      data_val_i = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && (exp_q.size() != 0 || exp6_q.size() != 0); i++) begin
         @(negedge clk);
      end
      chk("drain_a", exp_q.size(), 32'd0);
      chk("drain_b", exp6_q.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      data_val_i  = 1'b0;
      data_i      = '0;
      data_last_i = 1'b0;
      mode_i      = 1'b0;
      rdy_force   = 1'b0;
      tog_en      = 1'b0;
      tog_v       = 1'b0;
      use6        = 1'b0;

      // Reset state: ready must be high even with downstream not ready.
      #12;
      chk("rst_val", {31'b0, data_val_o}, 32'd0);
      chk("rst_rdy", {31'b0, data_rdy_o}, 32'd1);
      chk("rst_sum", {16'b0, sum_o}, 32'd0);
      chk("rst_data", {26'b0, data_o}, 32'd0);
      @(negedge clk);
      rst_n     = 1'b1;
      rdy_force = 1'b1;
      @(posedge clk);
      #1;

      // All ones, one-beat frame; output appears on the fifth edge.
      expect_a(32, 32, 1'b1, 1'b0);
      send(32'hFFFF_FFFF, 1'b0, 1'b1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("lat_early", {31'b0, data_val_o}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_hit", {31'b0, data_val_o}, 32'd1);
      @(posedge clk);
      #1;
      drain();

      // Back-to-back frame.
      expect_a(4, 4, 1'b0, 1'b0);
      expect_a(8, 12, 1'b0, 1'b0);
      expect_a(2, 14, 1'b1, 1'b0);
      send(32'h0000_000F, 1'b0, 1'b0);
      send(32'h0000_00FF, 1'b0, 1'b0);
      send(32'h8000_0001, 1'b0, 1'b1);
      drain();

      // Mixed modes within one frame.
      expect_a(32, 32, 1'b0, 1'b0);
      expect_a(32, 64, 1'b1, 1'b0);
      send(32'h0000_0000, 1'b1, 1'b0);
      send(32'hFFFF_FFFF, 1'b0, 1'b1);
      drain();

      // Backpressure with ready toggling 1,0,0.
      tcnt   = 0;
      tog_en = 1'b1;
      expect_a(1, 1, 1'b0, 1'b0);
      expect_a(2, 3, 1'b0, 1'b0);
      expect_a(3, 6, 1'b0, 1'b0);
      expect_a(16, 22, 1'b0, 1'b0);
      expect_a(16, 38, 1'b0, 1'b0);
      expect_a(0, 38, 1'b1, 1'b0);
      send(32'h0000_0001, 1'b0, 1'b0);
      send(32'h0000_0003, 1'b0, 1'b0);
      send(32'h0000_0007, 1'b0, 1'b0);
      send(32'hF0F0_F0F0, 1'b1, 1'b0);
      send(32'hFFFF_0000, 1'b0, 1'b0);
      send(32'h0000_0000, 1'b0, 1'b1);
      drain();
      tog_en = 1'b0;
      @(posedge clk);
      #1;

      // Saturation on the 6-bit accumulator, then a fresh frame.
      use6 = 1'b1;
      expect_a(32, 32, 1'b0, 1'b0);
      expect_a(32, 64, 1'b0, 1'b0);
      expect_a(32, 96, 1'b1, 1'b0);
      expect_a(8, 8, 1'b1, 1'b0);
      expect_b(32, 32, 1'b0, 1'b0);
      expect_b(32, 63, 1'b0, 1'b1);
      expect_b(32, 63, 1'b1, 1'b1);
      expect_b(8, 8, 1'b1, 1'b0);
      send(32'hFFFF_FFFF, 1'b0, 1'b0);
      send(32'hFFFF_FFFF, 1'b0, 1'b0);
      send(32'hFFFF_FFFF, 1'b0, 1'b1);
      send(32'h0000_00FF, 1'b0, 1'b1);
      drain();
      use6 = 1'b0;

      // Reset mid-frame with one beat out and three in flight.
      expect_a(1, 1, 1'b0, 1'b0);
      send(32'h0000_0001, 1'b0, 1'b0);
      send(32'h0000_0001, 1'b0, 1'b0);
      send(32'h0000_0001, 1'b0, 1'b0);
      send(32'h0000_0001, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_val", {31'b0, data_val_o}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_val", {31'b0, data_val_o}, 32'd0);
      chk("mid_rst_data", {26'b0, data_o}, 32'd0);
      chk("mid_rst_sum", {16'b0, sum_o}, 32'd0);
      chk("mid_rst_last", {31'b0, last_o}, 32'd0);
      chk("mid_rst_sat", {31'b0, sat_o}, 32'd0);
      chk("mid_rst_rdy", {31'b0, data_rdy_o}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      expect_a(2, 2, 1'b1, 1'b0);
      send(32'h0000_0003, 1'b0, 1'b1);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
